// File: rtl/instr_loader_if.sv
// +----------------------------------------------------------------------------+
// | instr_loader_if                                                            |
// | Byte-stream handshake and instruction-RAM write port for instr_loader.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface instr_loader_if #(
  parameter int ADDR_W = 9
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  // master is the loader; slave is the byte source / RAM side
  modport master (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

`default_nettype wire

// File: rtl/instr_loader.sv
// +----------------------------------------------------------------------------+
// | instr_loader                                                               |
// | Packs a byte stream MSB-first into 32-bit words and writes them to         |
// | instruction RAM, stalling the CPU until the all-ones terminator lands.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module instr_loader #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  wire logic        CLOCK,
  input  wire logic        RESET_N,
  input  wire logic        start,
  instr_loader_if.master   bus,
  output logic [ADDR_W:0]  word_count,
  output logic             load_done,
  output logic             overflow,
  output logic             cpu_hold
);

  localparam logic [31:0]       c_TERMINATOR = 32'hFFFF_FFFF;
  localparam logic [ADDR_W-1:0] c_LAST_ADDR  = ADDR_W'(DEPTH - 1);

  generate
    if (ADDR_W != $clog2(DEPTH)) begin : g_param_check
      $error("instr_loader: ADDR_W must equal log2(DEPTH)");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_shift;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic [ADDR_W:0]   r_word_count;
  logic              w_ready;
  logic              w_hs;

  assign w_ready = (r_state == S_LOAD);
  assign w_hs    = bus.byte_valid & w_ready;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The end-of-load decision is taken on the edge that closes the write cycle
  always_comb begin
    w_next_state = r_state;
    if (start) begin
      w_next_state = S_LOAD;
    end else if (r_state == S_LOAD && r_wr_en) begin
      if (r_wr_data == c_TERMINATOR) begin
        w_next_state = S_DONE;
      end else if (r_wr_addr == c_LAST_ADDR) begin
        w_next_state = S_ERROR;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_byte_idx   <= 2'd0;
      r_shift      <= 24'd0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= 32'd0;
      r_word_count <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (start) begin
        // start outranks a coincident byte, which is dropped with any partial word
        r_byte_idx   <= 2'd0;
        r_shift      <= 24'd0;
        r_word_count <= '0;
      end else if (w_hs) begin
        r_shift    <= {r_shift[15:0], bus.byte_data};
        r_byte_idx <= r_byte_idx + 2'd1;
        if (r_byte_idx == 2'd3) begin
          r_wr_en      <= 1'b1;
          r_wr_addr    <= r_word_count[ADDR_W-1:0];
          r_wr_data    <= {r_shift, bus.byte_data};
          r_word_count <= r_word_count + 1'b1;
        end
      end
    end
  end

  assign bus.byte_ready = w_ready;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign word_count     = r_word_count;
  assign load_done      = (r_state == S_DONE);
  assign overflow       = (r_state == S_ERROR);
  assign cpu_hold       = (r_state == S_LOAD) || (r_state == S_ERROR);

endmodule

`default_nettype wire

// File: tb/tb_instr_loader.sv
// +----------------------------------------------------------------------------+
// | tb_instr_loader                                                            |
// | Directed bench for instr_loader with a write monitor and hand-set values.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_instr_loader;

  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              load_done;
  logic              overflow;
  logic              cpu_hold;

  instr_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLOCK      (clk),
    .RESET_N    (rst_n),
    .start      (start),
    .bus        (bus.master),
    .word_count (word_count),
    .load_done  (load_done),
    .overflow   (overflow),
    .cpu_hold   (cpu_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // write monitor: logs every write and its distance from the 4th accepted byte
  logic [ADDR_W-1:0] wq_addr[$];
  logic [31:0]       wq_data[$];
  int                wq_lat[$];
  int                cyc   = 0;
  int                hs    = 0;
  int                last4 = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.wr_en) begin
      wq_addr.push_back(bus.wr_addr);
      wq_data.push_back(bus.wr_data);
      wq_lat.push_back(cyc - last4);
    end
    if (!rst_n || start) begin
      hs = 0;
    end else if (bus.byte_valid && bus.byte_ready) begin
      hs++;
      if (hs % 4 == 0) last4 = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_lat.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    tick();
    bus.byte_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8],  gap);
    send_byte(w[7:0],   gap);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) tick();

    // reset state
    check("rst_ready", bus.byte_ready, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_count", word_count, 0);
    check("rst_done", load_done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_hold", cpu_hold, 0);
    rst_n = 1'b1;
    tick();

    // 1: back-to-back program plus terminator
    clear_log();
    pulse_start();
    check("t1_ready", bus.byte_ready, 1);
    check("t1_hold", cpu_hold, 1);
    send_word(32'h2008_0005, 0);
    check("t1_cnt_mid", word_count, 1);
    send_word(32'hFFFF_FFFF, 0);
    tick();
    check("t1_nwr", wq_addr.size(), 2);
    check("t1_a0", wq_addr[0], 0);
    check("t1_d0", wq_data[0], 32'h2008_0005);
    check("t1_a1", wq_addr[1], 1);
    check("t1_d1", wq_data[1], 32'hFFFF_FFFF);
    check("t1_done", load_done, 1);
    check("t1_count", word_count, 2);
    check("t1_hold_off", cpu_hold, 0);
    check("t1_ready_off", bus.byte_ready, 0);
    check("t1_hold_addr", bus.wr_addr, 1);
    check("t1_hold_data", bus.wr_data, 32'hFFFF_FFFF);

    // 2: same stream, valid every third cycle
    clear_log();
    pulse_start();
    check("t2_done_drop", load_done, 0);
    send_word(32'h2008_0005, 2);
    send_word(32'hFFFF_FFFF, 2);
    tick();
    check("t2_nwr", wq_addr.size(), 2);
    check("t2_a0", wq_addr[0], 0);
    check("t2_d0", wq_data[0], 32'h2008_0005);
    check("t2_lat0", wq_lat[0], 1);
    check("t2_a1", wq_addr[1], 1);
    check("t2_d1", wq_data[1], 32'hFFFF_FFFF);
    check("t2_lat1", wq_lat[1], 1);
    check("t2_done", load_done, 1);

    // 3: fill the RAM without a terminator
    clear_log();
    pulse_start();
    for (int w = 0; w < DEPTH; w++) send_word(32'h0, 0);
    tick();
    check("t3_nwr", wq_addr.size(), DEPTH);
    begin
      int errs;
      errs = 0;
      foreach (wq_addr[i]) begin
        if (wq_addr[i] != ADDR_W'(i) || wq_data[i] != 32'h0 || wq_lat[i] != 1) errs++;
      end
      check("t3_seq", errs, 0);
    end
    check("t3_ovf", overflow, 1);
    check("t3_count", word_count, DEPTH);
    check("t3_hold", cpu_hold, 1);
    check("t3_ready", bus.byte_ready, 0);
    check("t3_done", load_done, 0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h00;
    repeat (16) tick();
    bus.byte_valid = 1'b0;
    check("t3_nwr_after", wq_addr.size(), DEPTH);
    check("t3_ovf_hold", overflow, 1);

    // 4: restart mid-word discards the partial bytes
    clear_log();
    pulse_start();
    check("t4_ovf_clr", overflow, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    pulse_start();
    send_word(32'h8C01_0004, 0);
    send_word(32'hFFFF_FFFF, 0);
    tick();
    check("t4_nwr", wq_addr.size(), 2);
    check("t4_a0", wq_addr[0], 0);
    check("t4_d0", wq_data[0], 32'h8C01_0004);
    check("t4_d1", wq_data[1], 32'hFFFF_FFFF);
    check("t4_count", word_count, 2);

    // 5: asynchronous reset after six bytes
    clear_log();
    pulse_start();
    send_word(32'h2008_0005, 0);
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_wr_en", bus.wr_en, 0);
    check("t5_ready", bus.byte_ready, 0);
    check("t5_hold", cpu_hold, 0);
    check("t5_count", word_count, 0);
    check("t5_addr", bus.wr_addr, 0);
    check("t5_data", bus.wr_data, 0);
    #4 rst_n = 1'b1;
    tick();
    repeat (3) tick();
    check("t5_nwr_pre", wq_addr.size(), 1);
    pulse_start();
    send_word(32'h0000_0007, 0);
    send_word(32'hFFFF_FFFF, 0);
    tick();
    check("t5_nwr", wq_addr.size(), 3);
    check("t5_a1", wq_addr[1], 0);
    check("t5_d1", wq_data[1], 32'h0000_0007);
    check("t5_a2", wq_addr[2], 1);
    check("t5_done", load_done, 1);

    // 6: terminator-only reload from DONE
    clear_log();
    start = 1'b1;
    #1;
    check("t6_done_pre", load_done, 1);
    tick();
    start = 1'b0;
    check("t6_done_drop", load_done, 0);
    send_word(32'hFFFF_FFFF, 0);
    tick();
    check("t6_nwr", wq_addr.size(), 1);
    check("t6_a0", wq_addr[0], 0);
    check("t6_d0", wq_data[0], 32'hFFFF_FFFF);
    check("t6_done", load_done, 1);
    check("t6_count", word_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer side of the instruction memory: receives a byte stream over a valid/ready handshake and assembles it into 32-bit words, MSB byte first.
- Writes each word into instruction RAM at sequential word addresses starting from 0.
- Holds the fetch pipeline (cpu_hold) while loading. Finishes on the 32'hFFFFFFFF terminator word, which is itself written because fetch-side end detection relies on it.

Parameters:
DEPTH, 512, number of 32-bit words in instruction RAM
ADDR_W, 9, word-address width; must equal log2(DEPTH)

Ports:
CLOCK  input  1  rising-edge clock
RESET_N  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; clears the loader and begins a load
byte_valid  input  1  byte_data is valid this cycle
byte_data  input  8  incoming program byte
byte_ready  output  1  loader accepts a byte this cycle
wr_en  output  1  instruction RAM write strobe, one cycle per word
wr_addr  output  ADDR_W  word address of the write (byte address / 4)
wr_data  output  32  assembled instruction word
word_count  output  ADDR_W+1  number of words written in the current load, terminator included
load_done  output  1  terminator written; level, held until start or reset
overflow  output  1  RAM filled without a terminator; level, held until start or reset
cpu_hold  output  1  stall request to the PC register

Behaviour:
- Reset (RESET_N=0, asynchronous): state IDLE. All outputs 0: byte_ready, wr_en, wr_addr, wr_data, word_count, load_done, overflow, cpu_hold. Internal byte index and shift register cleared. Reset asserted mid-load discards the partial word; no write is issued.
- States: IDLE, LOAD, DONE, ERROR.
- start=1 in any state → LOAD on the next edge:
  - byte index=0, word_count=0, load_done=0, overflow=0.
  - A start during LOAD aborts the current load and restarts at address 0.
  - A start in the same cycle as a byte handshake wins; the byte is dropped.
- LOAD:
  - byte_ready=1 and cpu_hold=1.
  - A handshake is byte_valid & byte_ready at a rising edge.
  - Each handshake shifts byte_data in: word = {word[23:0], byte_data}; byte index increments modulo 4.
- Write timing: on the handshake completing byte 3, the next cycle shows:
  - wr_en=1 for exactly one cycle;
  - wr_addr=word_count[ADDR_W-1:0] (pre-increment value);
  - wr_data=the assembled word;
  - word_count increments in that same cycle.
  - Latency from 4th-byte edge to wr_en high: 1 cycle.
- wr_addr/wr_data hold their last values while wr_en=0.
- byte_ready stays 1 during the write cycle, so back-to-back bytes sustain 1 word per 4 cycles.
- Terminator: if the written word equals 32'hFFFFFFFF, the state moves to DONE on the edge ending the write cycle. In the DONE cycle: load_done=1, cpu_hold=0, byte_ready=0.
- Overflow: if the write goes to address DEPTH-1 and the word is not the terminator, the state moves to ERROR:
  - overflow=1, cpu_hold=1, byte_ready=0;
  - no wrap-around to address 0; no further writes.
- Terminator at address DEPTH-1 → DONE, not ERROR.
- In IDLE/DONE/ERROR, byte_valid is ignored and no writes occur.
- IDLE: cpu_hold=0, byte_ready=0.
- word_count maximum is DEPTH, hence ADDR_W+1 bits wide.
- Partial words (1–3 bytes) remaining when start or reset hits are discarded silently.

Test Plan:
1. Reset, start pulse, then bytes 20 08 00 05 FF FF FF FF on consecutive cycles → exactly two writes:
   - wr_addr=0, wr_data=32'h20080005;
   - then wr_addr=1, wr_data=32'hFFFFFFFF;
   - then load_done=1, word_count=2, cpu_hold=0, byte_ready=0.
2. Same stream with byte_valid gapped (valid on every 3rd cycle) → identical writes. Each wr_en occurs 1 cycle after its 4th handshake; no write comes from the gaps.
3. Start, stream 512 words of 32'h00000000 with no terminator → writes at addresses 0..511 only, then overflow=1, word_count=512, cpu_hold=1, and no wr_en afterwards despite continued byte_valid.
4. Start, 2 bytes (AA BB), then start again, then 8C 01 00 04 FF FF FF FF → first write wr_addr=0, wr_data=32'h8C010004; the AA BB bytes never appear.
5. Mid-load, after 6 bytes, RESET_N low for a half cycle asynchronously → all outputs 0 immediately, no write. After release plus a start, the load begins again at address 0.
6. From DONE, start plus a terminator-only stream FF FF FF FF → load_done drops the cycle after start. A single write occurs at wr_addr=0 with 32'hFFFFFFFF, then load_done=1 and word_count=1.
